// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops bytes from a FIFO read port and serialises them as 8N1 frames.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit, giving 8E1 frames.
`timescale 1ns/1ps
module uart_fifo_tx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_deq,
  output logic             tx,
  output logic             busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH);
  localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIDX_LAST = IW'(WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif

  state_t           state;
  state_t           nxt;
  logic [BW-1:0]    bcnt;
  logic [IW-1:0]    bidx;
  logic [WIDTH-1:0] sh;
  logic             bit_end;
  logic             last_bit;
  logic             tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  assign bit_end  = (bcnt == BCNT_LAST);
  assign last_bit = (bidx == BIDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // tx_nxt is the line level for the current state; registering it keeps tx glitch-free.
  always_comb begin
    nxt    = state;
    tx_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) nxt = POP;
      end
      POP: begin
        nxt = LOAD;
      end
      LOAD: begin
        nxt = START;
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) nxt = DATA;
      end
      DATA: begin
        tx_nxt = sh[0];
        if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
          nxt = PARITY;
`else
          nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_nxt = par;
        if (bit_end) nxt = STOP;
      end
`endif
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_deq <= 1'b0;
      busy     <= 1'b0;
      tx       <= 1'b1;
      bcnt     <= '0;
      bidx     <= '0;
      sh       <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      fifo_deq <= (nxt == POP);
      busy     <= (nxt != IDLE);
      tx       <= tx_nxt;

      // Every state change restarts the bit period; idle keeps the counter parked at zero.
      if (nxt != state) begin
        bcnt <= '0;
      end else if (state != IDLE) begin
        bcnt <= bit_end ? '0 : bcnt + 1'b1;
      end

      if (state == LOAD) begin
        sh   <= fifo_dout;
        bidx <= '0;
`ifdef UART_TX_PARITY_EN
        par  <= even_parity(fifo_dout);
`endif
      end else if ((state == DATA) && bit_end) begin
        sh   <= sh >> 1;
        bidx <= last_bit ? '0 : bidx + 1'b1;
      end
    end
  end

`ifndef UART_TX_PARITY_EN
  logic unused_parity_fn;
  assign unused_parity_fn = even_parity('0);
`endif

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: a queue-backed FIFO feeds the DUT, the tx line is logged every
// cycle and compared against frames predicted from the byte stream and enqueue times.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int W      = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int FRAME = NB * CPB;
  localparam int LOGN  = 32768;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_deq;
  logic         tx;
  logic         busy;

  logic         enq_vld = 1'b0;
  logic [W-1:0] enq_byte = '0;
  logic [W-1:0] fq[$];
  logic         underflow = 1'b0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  logic tx_log   [LOGN];
  logic deq_log  [LOGN];
  logic busy_log [LOGN];

  uart_fifo_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_deq(fifo_deq), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-output FIFO: a sampled dequeue presents the popped byte after the same edge.
  always @(posedge clk) begin
    if (fifo_deq) begin
      if (fq.size() > 0) fifo_dout <= fq.pop_front();
      else underflow <= 1'b1;
    end
    if (enq_vld) fq.push_back(enq_byte);
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]   = tx;
      deq_log[cyc]  = fifo_deq;
      busy_log[cyc] = busy;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // Reference line level k cycles into a frame carrying byte b.
  function automatic logic exp_level(input logic [W-1:0] b, input int k);
    int i;
    i = k / CPB;
    if (i == 0) return 1'b0;
    if (i <= W) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == W + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic int frame_errs(input logic [W-1:0] b, input int t0);
    int n;
    n = 0;
    if (tx_log[t0-1] !== 1'b1) n++;
    for (int k = 0; k < FRAME; k++)
      if (tx_log[t0+k] !== exp_level(b, k)) n++;
    return n;
  endfunction

  function automatic int find_fall(input int a, input int z);
    for (int c = a; c <= z; c++)
      if (tx_log[c-1] === 1'b1 && tx_log[c] === 1'b0) return c;
    return -1;
  endfunction

  function automatic int count_deq(input int a, input int z);
    int n;
    n = 0;
    for (int c = a; c <= z; c++) if (deq_log[c] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_busy(input int a, input int z);
    int n;
    n = 0;
    for (int c = a; c <= z; c++) if (busy_log[c] === 1'b1) n++;
    return n;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic enq(input logic [W-1:0] b, output int e);
    @(negedge clk);
    enq_vld  = 1'b1;
    enq_byte = b;
    @(negedge clk);
    enq_vld  = 1'b0;
    e = cyc;
  endtask

  task automatic test_reset();
    int c0, btx, bdq, bby;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_deq !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: tx=%b busy=%b deq=%b, want 1 0 0", tx, busy, fifo_deq);
    end
    reset = 1'b0;
    c0 = cyc;
    wait_cyc(c0 + 102);
    btx = 0; bdq = 0; bby = 0;
    for (int c = c0 + 1; c <= c0 + 100; c++) begin
      if (tx_log[c] !== 1'b1) btx++;
      if (deq_log[c] !== 1'b0) bdq++;
      if (busy_log[c] !== 1'b0) bby++;
    end
    tests++;
    if (btx !== 0) begin fails++; $display("FAIL idle_tx: %0d cycles not high, want 0", btx); end
    tests++;
    if (bdq !== 0) begin fails++; $display("FAIL idle_deq: %0d dequeue cycles, want 0", bdq); end
    tests++;
    if (bby !== 0) begin fails++; $display("FAIL idle_busy: %0d busy cycles, want 0", bby); end
  endtask

  task automatic test_single();
    int e, t0, n;
    enq(8'h55, e);
    t0 = e + 4;
    wait_cyc(t0 + FRAME + 30);
    tests++;
    if (deq_log[e+1] !== 1'b1) begin
      fails++; $display("FAIL single_deq_timing: deq=%b one cycle after sample, want 1", deq_log[e+1]);
    end
    n = count_deq(e - 2, t0 + FRAME + 25);
    tests++;
    if (n !== 1) begin fails++; $display("FAIL single_deq_count: %0d pulses, want 1", n); end
    n = find_fall(e, t0 + 20);
    tests++;
    if (n !== t0) begin fails++; $display("FAIL single_start: fall at %0d, want %0d", n, t0); end
    n = frame_errs(8'h55, t0);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL single_frame: %0d wrong bit-cycles for 55, want 0", n); end
    n = count_busy(e - 2, t0 + FRAME + 25);
    tests++;
    if (n !== FRAME + 2 || busy_log[e+1] !== 1'b1) begin
      fails++; $display("FAIL single_busy: %0d busy cycles, want %0d", n, FRAME + 2);
    end
  endtask

  task automatic test_back_to_back();
    int e0, e1, t0, t1, n;
    enq(8'hA3, e0);
    enq(8'h0F, e1);
    t0 = e0 + 4;
    t1 = t0 + FRAME + 3;
    wait_cyc(t1 + FRAME + 20);
    n = frame_errs(8'hA3, t0);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL b2b_frame0: %0d wrong bit-cycles for A3, want 0", n); end
    n = frame_errs(8'h0F, t1);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL b2b_frame1: %0d wrong bit-cycles for 0F, want 0", n); end
    n = find_fall(t0 + FRAME, t0 + FRAME + 30) - (t0 + FRAME);
    tests++;
    if (n !== 3) begin fails++; $display("FAIL b2b_gap: %0d idle cycles, want 3", n); end
    n = count_deq(e0 - 2, t1 + FRAME + 15);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL b2b_deq_count: %0d pulses, want 2", n); end
  endtask

  task automatic test_random();
    logic [W-1:0] b [6];
    int t0s [6];
    int e, smp, prev, ws, n;
    ws = cyc;
    prev = -100000;
    for (int i = 0; i < 6; i++) begin
      b[i] = W'($urandom);
      repeat ($urandom_range(0, FRAME + 20)) @(negedge clk);
      enq(b[i], e);
      // The DUT first samples the flag one edge after the push, but never before the line is free again.
      smp = (e + 1 > prev + FRAME) ? e + 1 : prev + FRAME;
      t0s[i] = smp + 3;
      prev = t0s[i];
    end
    wait_cyc(prev + FRAME + 20);
    for (int i = 0; i < 6; i++) begin
      n = frame_errs(b[i], t0s[i]);
      tests++;
      if (n !== 0) begin
        fails++;
        $display("FAIL random_frame%0d: %0d wrong bit-cycles for %02h at %0d, want 0", i, n, b[i], t0s[i]);
      end
    end
    n = count_deq(ws, prev + FRAME + 15);
    tests++;
    if (n !== 6) begin fails++; $display("FAIL random_deq_count: %0d pulses, want 6", n); end
  endtask

  task automatic test_reset_mid_data();
    logic [W-1:0] r;
    int e0, e1, t0, c, n;
    r = W'($urandom);
    enq(8'hFF, e0);
    enq(r, e1);
    t0 = e0 + 4;
    while (cyc < t0 + 35) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_deq !== 1'b0) begin
      fails++; $display("FAIL reset_async: tx=%b busy=%b deq=%b, want 1 0 0", tx, busy, fifo_deq);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    c = cyc;
    wait_cyc(c + 4 + FRAME + 20);
    n = frame_errs(r, c + 4);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL reset_next_frame: %0d wrong bit-cycles for %02h, want 0", n, r); end
    n = count_deq(e0 - 2, c + FRAME + 20);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL reset_deq_count: %0d pulses, want 2", n); end
  endtask

  task automatic test_stop_enqueue();
    logic [W-1:0] a, b;
    int e0, e1, t0, n;
    a = W'($urandom);
    b = W'($urandom);
    enq(a, e0);
    t0 = e0 + 4;
    while (cyc < t0 + FRAME - 9) @(negedge clk);
    enq(b, e1);
    wait_cyc(t0 + 2 * FRAME + 20);
    n = count_deq(e1 - 3, t0 + FRAME - 1);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL stop_early_deq: %0d pulses before idle, want 0", n); end
    tests++;
    if (deq_log[t0+FRAME] !== 1'b1) begin
      fails++; $display("FAIL stop_deq_timing: deq=%b at first idle sample, want 1", deq_log[t0+FRAME]);
    end
    n = frame_errs(a, t0);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL stop_frame0: %0d wrong bit-cycles for %02h, want 0", n, a); end
    n = frame_errs(b, t0 + FRAME + 3);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL stop_frame1: %0d wrong bit-cycles for %02h, want 0", n, b); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int e, t0, n, ones;
    enq(8'h07, e);
    t0 = e + 4;
    wait_cyc(t0 + FRAME + 20);
    ones = 0;
    for (int c = t0 + 9 * CPB; c < t0 + 10 * CPB; c++) if (tx_log[c] === 1'b1) ones++;
    tests++;
    if (ones !== CPB) begin fails++; $display("FAIL parity_07: %0d high cycles in parity bit, want %0d", ones, CPB); end
    n = count_busy(e - 2, t0 + FRAME + 15);
    tests++;
    if (n !== 112 || frame_errs(8'h07, t0) !== 0) begin
      fails++; $display("FAIL parity_len: %0d busy cycles, want 112 with clean 110-cycle frame", n);
    end
    enq(8'h03, e);
    t0 = e + 4;
    wait_cyc(t0 + FRAME + 20);
    ones = 0;
    for (int c = t0 + 9 * CPB; c < t0 + 10 * CPB; c++) if (tx_log[c] === 1'b1) ones++;
    tests++;
    if (ones !== 0) begin fails++; $display("FAIL parity_03: %0d high cycles in parity bit, want 0", ones); end
  endtask
`endif

  task automatic test_no_underflow();
    tests++;
    if (underflow !== 1'b0) begin fails++; $display("FAIL underflow: deq on empty FIFO seen=%b, want 0", underflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_reset_mid_data();
    test_stop_enqueue();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_no_underflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

UART transmitter that drains the byte FIFO from its read side. Whenever the FIFO reports data, the block issues a single dequeue pulse and captures the byte the FIFO holds on its output. It then serialises the byte onto `tx` as an 8N1 frame, or 8E1 when parity is compiled in. It is the consumer counterpart of the FIFO's enqueue side and sits between the FIFO and the board's UART TX pin.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT` = `CLK_HZ` / `BAUD`, integer division, truncated. The value must be ≥ 2.
- `WIDTH`, default 8: data bits per frame. Must match the FIFO width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_dout`, in, `WIDTH`: FIFO output data. It is registered in the FIFO and updated on the edge that samples a dequeue.
- `fifo_deq`, out, 1: dequeue request. Registered, one-cycle pulse.
- `tx`, out, 1: serial line output. Registered; idles high.
- `busy`, out, 1: high while a byte is being fetched or transmitted.

## Operation
- States:
  - `IDLE`
  - `POP`
  - `LOAD`
  - `START`
  - `DATA`
  - `PARITY` (only with the macro)
  - `STOP`
- Baud counter `bcnt` has width $clog2(`CLKS_PER_BIT`). Each bit period lasts exactly `CLKS_PER_BIT` cycles. The counter clears on every state change into `START`, `DATA`, `PARITY` or `STOP`.
- Bit index `bidx` has width $clog2(`WIDTH`) and counts 0..`WIDTH`-1.
- State transitions:
  - `IDLE` → `POP` on the first clock edge that samples `fifo_empty` == 0. Otherwise stay in `IDLE`.
  - `POP` → `LOAD` unconditionally. `fifo_deq` is 1 during `POP` only.
  - `LOAD` → `START`. On this edge, `fifo_dout` is captured into the shift register `sh`. The FIFO has updated `dout` at the end of `POP`.
  - `START` → `DATA` after `CLKS_PER_BIT` cycles. `tx` = 0 throughout.
  - `DATA`: `tx` = `sh[0]`, LSB first. At the end of each bit period, `sh` shifts right and `bidx` increments. After bit `WIDTH`-1, go to `PARITY` (macro defined) or to `STOP`.
  - `STOP` → `IDLE` after `CLKS_PER_BIT` cycles. `tx` = 1 throughout.
- `busy` = 1 in every state except `IDLE`.
- Exactly one `fifo_deq` pulse is issued per transmitted byte. `fifo_deq` is never asserted while `fifo_empty` was 1 at the `IDLE` sample.
- `fifo_empty` is ignored outside `IDLE`. Bytes enqueued mid-frame wait for the next `IDLE`.
- Reset:
  - Asynchronous, with immediate effect: `tx` = 1, `fifo_deq` = 0, `busy` = 0, state = `IDLE`, `bcnt` = 0, `bidx` = 0, `sh` = 0.
  - A frame in progress is truncated and its byte is lost. This is not an error; the line simply returns high.
  - A reset asserted during `POP` or `LOAD` discards the dequeued byte.

## Timing
- `fifo_empty` seen low at edge N:
  - `fifo_deq` is high for cycle N+1.
  - The byte is latched at edge N+2.
  - The falling edge of `tx` (start bit) appears after edge N+3.
- Frame length:
  - 1 + `WIDTH` + 1 bit periods.
  - One more bit period with parity compiled in.
- Back-to-back bytes:
  - `STOP` ends and the state enters `IDLE`.
  - 3 extra idle-high cycles (`IDLE`, `POP`, `LOAD`) separate the stop bit from the next start bit.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - `PARITY` state inserted after `DATA`.
  - `tx` = even parity, i.e. XOR of all `WIDTH` data bits, computed at `LOAD` and held for one bit period.
  - Frame is 8E1.
- Undefined:
  - `PARITY` state and parity register are absent.
  - Frame is 8N1.

## Test plan
All scenarios use `CLK_HZ`=1_000_000 and `BAUD`=100_000 (10 clocks per bit) unless noted.
- Reset, FIFO empty for 100 cycles:
  - `tx`=1, `fifo_deq`=0, `busy`=0 for the whole window.
- Single byte 0x55 enqueued:
  - Exactly one `fifo_deq` pulse.
  - `tx` start bit falls 3 cycles after the first `fifo_empty`=0 sample.
  - Data bits are 1,0,1,0,1,0,1,0, each held 10 cycles.
  - Stop bit is high.
  - `busy` drops after 100 cycles of frame.
- Bytes 0xA3 then 0x0F enqueued back-to-back:
  - Two frames in order, LSB first.
  - Gap between stop-bit end and the second start bit is 3 cycles.
  - Exactly 2 dequeue pulses in total.
- Reset asserted mid-`DATA` of 0xFF:
  - `tx` goes to 1 immediately and the state returns to `IDLE`.
  - After release with the FIFO still non-empty, the next byte is transmitted cleanly.
- Byte enqueued during the stop bit of the previous frame:
  - No `fifo_deq` before `IDLE`.
  - The next frame is sent with the 3-cycle gap.
- With `UART_TX_PARITY_EN` defined, byte 0x07:
  - Parity bit 1 and frame length 110 cycles.
- With `UART_TX_PARITY_EN` defined, byte 0x03:
  - Parity bit 0.
